// File: rtl/tortoise_pkg.sv
// Shared core types for the tortoise pipeline: fetch entry records, exception and
// branch-prediction sidebands, and sizing constants used at instantiation.
package tortoise_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned ILEN             = 32;
  localparam int unsigned FETCH_FIFO_DEPTH = 4;

  typedef enum logic [3:0] {
    INSTR_ADDR_MISALIGNED = 4'd0,
    INSTR_ACCESS_FAULT    = 4'd1,
    ILLEGAL_INSTR         = 4'd2,
    BREAKPOINT            = 4'd3,
    LOAD_ADDR_MISALIGNED  = 4'd4,
    LOAD_ACCESS_FAULT     = 4'd5,
    STORE_ADDR_MISALIGNED = 4'd6,
    STORE_ACCESS_FAULT    = 4'd7,
    ENV_CALL_UMODE        = 4'd8,
    ENV_CALL_SMODE        = 4'd9,
    ENV_CALL_MMODE        = 4'd11,
    INSTR_PAGE_FAULT      = 4'd12,
    LOAD_PAGE_FAULT       = 4'd13,
    STORE_PAGE_FAULT      = 4'd15
  } exc_cause_e;

  typedef struct packed {
    logic            valid;
    exc_cause_e      cause;
    logic [XLEN-1:0] tval;
  } exception_t;

  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] target;
  } branch_predict_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            is_compressed;
    branch_predict_t predict;
    exception_t      ex;
  } fetch_entry_t;

  // All-zero entry, presented to the decoder whenever nothing is buffered.
  function automatic fetch_entry_t fetch_entry_blank();
    fetch_entry_t e;
    e = '0;
    return e;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between fetch and decode: circular buffer with registered
// occupancy, one-cycle latency (no fall-through) and single-cycle flush.
module fetch_fifo
  import tortoise_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_FIFO_DEPTH,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  fetch_entry_t fetch_i,
  output logic         fetch_ready_o,
  output fetch_entry_t decode_o,
  input  logic         decode_ack_i,
  output logic [PTR_W:0] count_o
);

  localparam logic [PTR_W:0]   CountFull = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PtrOne    = PTR_W'(1);

  fetch_entry_t   mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic not_empty;
  logic push;
  logic pop;

  assign not_empty     = (count_q != '0);
  // Ready is purely registered so there is no path from decode_ack_i back to fetch.
  assign fetch_ready_o = (count_q != CountFull);
  assign count_o       = count_q;

  assign push = fetch_i.valid & fetch_ready_o & ~flush_i;
  assign pop  = decode_ack_i & not_empty & ~flush_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only exposed while count is non-zero.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= fetch_i;
    end
  end

  always_comb begin
    decode_o = fetch_entry_blank();
    if (not_empty) begin
      decode_o       = mem_q[rd_ptr_q];
      decode_o.valid = 1'b1;
    end
  end

  a_count_bound : assert property (@(posedge clk_i) disable iff (rst_i)
    count_q <= CountFull);

  a_no_push_full : assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && (count_q == CountFull)));

  // count == DEPTH has zero low bits, so the full case also reduces to rd == wr.
  a_ptr_consistent : assert property (@(posedge clk_i) disable iff (rst_i)
    PTR_W'(rd_ptr_q + count_q[PTR_W-1:0]) == wr_ptr_q);

endmodule

// File: tb/tb_fetch_fifo.sv
// Directed bench for fetch_fifo: reset, latency, fill/full, streaming wrap,
// flush, exception passthrough and mid-stream reset.
module tb_fetch_fifo;
  import tortoise_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic           clk;
  logic           rst;
  logic           flush;
  fetch_entry_t   fetch;
  logic           fetch_ready;
  fetch_entry_t   decode;
  logic           decode_ack;
  logic [PTR_W:0] count;

  int errors = 0;
  int checks = 0;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush),
    .fetch_i       (fetch),
    .fetch_ready_o (fetch_ready),
    .decode_o      (decode),
    .decode_ack_i  (decode_ack),
    .count_o       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_push(input logic [31:0] pc);
    fetch       = '0;
    fetch.valid = 1'b1;
    fetch.pc    = pc;
    fetch.instr = pc ^ 32'h0000_0013;
  endtask

  task automatic chk_state(input string tag, input logic ready, input logic valid,
                           input int unsigned cnt);
    chk({tag, ".ready"}, 64'(fetch_ready), 64'(ready));
    chk({tag, ".valid"}, 64'(decode.valid), 64'(valid));
    chk({tag, ".count"}, 64'(count), 64'(cnt));
  endtask

  exception_t      exp_ex;
  branch_predict_t exp_pred;

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    fetch      = '0;
    decode_ack = 1'b0;
    step();
    rst = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 5; i++) begin
      step();
      chk_state("idle", 1'b1, 1'b0, 0);
    end
    chk("idle.pc_zero", 64'(decode.pc), 64'h0);

    // Single push: visible the following cycle.
    set_push(32'h8000_0000);
    step();
    fetch = '0;
    chk_state("single", 1'b1, 1'b1, 1);
    chk("single.pc", 64'(decode.pc), 64'h8000_0000);
    decode_ack = 1'b1;
    step();
    decode_ack = 1'b0;
    chk_state("single_pop", 1'b1, 1'b0, 0);

    // Fill to DEPTH.
    for (int i = 0; i < 4; i++) begin
      set_push(32'h100 + 32'(4 * i));
      step();
    end
    chk_state("full", 1'b0, 1'b1, 4);
    chk("full.pc", 64'(decode.pc), 64'h100);

    // Push while full is dropped.
    set_push(32'h110);
    step();
    chk_state("full_push", 1'b0, 1'b1, 4);
    chk("full_push.pc", 64'(decode.pc), 64'h100);

    // Push + ack while full: only the pop happens.
    decode_ack = 1'b1;
    step();
    fetch = '0;
    chk_state("full_ackpush", 1'b1, 1'b1, 3);
    chk("full_ackpush.pc", 64'(decode.pc), 64'h104);

    for (int i = 2; i < 4; i++) begin
      step();
      chk("drain.pc", 64'(decode.pc), 64'(32'h100 + 32'(4 * i)));
      chk("drain.count", 64'(count), 64'(4 - i));
    end
    step();
    decode_ack = 1'b0;
    chk_state("drained", 1'b1, 1'b0, 0);
    chk("drained.pc_zero", 64'(decode.pc), 64'h0);

    // Ack on empty is ignored.
    decode_ack = 1'b1;
    step();
    decode_ack = 1'b0;
    chk_state("empty_ack", 1'b1, 1'b0, 0);

    // Streaming: push and ack every cycle, 12 entries through.
    set_push(32'h400);
    step();
    for (int i = 1; i <= 12; i++) begin
      chk("stream.pc", 64'(decode.pc), 64'(32'h400 + 32'(4 * (i - 1))));
      set_push(32'h400 + 32'(4 * i));
      decode_ack = 1'b1;
      step();
      chk("stream.count", 64'(count), 64'd1);
    end
    fetch = '0;
    chk("stream.last_pc", 64'(decode.pc), 64'(32'h400 + 32'(4 * 12)));
    step();
    decode_ack = 1'b0;
    chk_state("stream_end", 1'b1, 1'b0, 0);

    // Flush with simultaneous push and ack.
    for (int i = 0; i < 3; i++) begin
      set_push(32'h500 + 32'(4 * i));
      step();
    end
    chk("preflush.count", 64'(count), 64'd3);
    set_push(32'h200);
    flush      = 1'b1;
    decode_ack = 1'b1;
    step();
    flush      = 1'b0;
    decode_ack = 1'b0;
    fetch      = '0;
    chk_state("flush", 1'b1, 1'b0, 0);
    set_push(32'h300);
    step();
    fetch = '0;
    chk_state("post_flush", 1'b1, 1'b1, 1);
    chk("post_flush.pc", 64'(decode.pc), 64'h300);
    decode_ack = 1'b1;
    step();
    decode_ack = 1'b0;
    chk_state("post_flush_pop", 1'b1, 1'b0, 0);

    // Exception and prediction sidebands pass through unmodified.
    exp_ex.valid     = 1'b1;
    exp_ex.cause     = INSTR_PAGE_FAULT;
    exp_ex.tval      = 32'h0000_DEAD;
    exp_pred.taken   = 1'b1;
    exp_pred.target  = 32'h0000_1234;
    set_push(32'h600);
    fetch.instr         = 32'h0;
    fetch.is_compressed = 1'b1;
    fetch.ex            = exp_ex;
    fetch.predict       = exp_pred;
    step();
    fetch = '0;
    chk("exc.ex", 64'(decode.ex), 64'(37'h1_C000_0DEAD));
    chk("exc.predict", 64'(decode.predict), 64'(33'h1_0000_1234));
    chk("exc.compressed", 64'(decode.is_compressed), 64'd1);
    chk("exc.pc", 64'(decode.pc), 64'h600);
    decode_ack = 1'b1;
    step();
    decode_ack = 1'b0;

    // Reset mid-operation with a push in the same cycle.
    set_push(32'h700);
    step();
    set_push(32'h704);
    step();
    chk("prereset.count", 64'(count), 64'd2);
    set_push(32'h708);
    rst = 1'b1;
    step();
    rst   = 1'b0;
    fetch = '0;
    chk_state("midreset", 1'b1, 1'b0, 0);
    step();
    chk_state("midreset_idle", 1'b1, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_fifo.md
Name: fetch_fifo

Overview:
- Instruction buffer between the frontend (fetch) and the decoder.
- Decouples fetch latency from decode/issue stalls by holding up to DEPTH fetch_entry_t records in program order.
- Presents the oldest entry combinationally to the decoder, and drops all contents on a pipeline flush.
- Storage is a circular buffer with read/write pointers and an occupancy counter.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH), pointer width (derived; do not override).

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  discard all buffered entries (branch mispredict / exception / fence.i).
- fetch_i  in  fetch_entry_t  entry from frontend; fetch_i.valid is the push request.
- fetch_ready_o  out  1  FIFO can accept a push this cycle.
- decode_o  out  fetch_entry_t  oldest entry, to the decoder's fetch_i; decode_o.valid=1 iff non-empty.
- decode_ack_i  in  1  decoder/issue consumed decode_o this cycle (pop).
- count_o  out  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst_i=1 at an edge):
  - rd_ptr=0, wr_ptr=0, count=0.
  - Outputs after reset: fetch_ready_o=1, decode_o.valid=0, count_o=0.
  - Storage contents are don't-care, but decode_o fields other than valid are driven to 0 when empty.
- Handshake rules:
  - push = fetch_i.valid & fetch_ready_o & ~flush_i.
  - pop = decode_ack_i & decode_o.valid & ~flush_i.
- fetch_ready_o = (count != DEPTH). It depends only on registered state, with no combinational path from decode_ack_i or fetch_i.
- No fall-through. An entry pushed at edge N is visible on decode_o from cycle N+1; latency is 1 cycle through an empty FIFO.
- decode_o:
  - Equals mem[rd_ptr] with valid forced to (count!=0).
  - All other fields, including ex, pc and predict, pass through unmodified.
- Push: mem[wr_ptr] <= fetch_i; wr_ptr <= wr_ptr+1, modulo DEPTH (natural PTR_W wrap).
- Pop: rd_ptr <= rd_ptr+1, modulo DEPTH.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop (possible when 0<count<DEPTH).
- When full: fetch_ready_o=0, and fetch_i.valid is ignored (no overwrite) even if decode_ack_i=1 in the same cycle. The freed slot is offered the next cycle.
- When empty: decode_ack_i is ignored; count never underflows.
- Flush:
  - Next cycle rd_ptr=wr_ptr=0 and count=0.
  - A push or pop requested in the flush cycle is discarded.
  - decode_o.valid=0 from the next cycle.
- Reset overrides flush. Reset asserted mid-stream behaves exactly as flush plus pointer clear.
- Exception entries (fetch_i.ex.valid=1) are buffered like any other entry; the FIFO never inspects them.
- Assertions (simulation only):
  - count_o <= DEPTH.
  - Never push when full.
  - rd_ptr + count == wr_ptr (mod DEPTH).

Decomposition:
- tortoise_pkg: fetch_entry_t (existing), plus constant FETCH_FIFO_DEPTH (default 4) used at instantiation.
- No sub-module. The pointer/count logic is small enough to live inline.
- The storage array is a plain register array; no SRAM macro.

Test Plan:
- Reset, then idle -> fetch_ready_o=1, decode_o.valid=0, count_o=0 for 5 cycles.
- Push pc=0x80000000 at cycle 1, no ack -> decode_o.valid=1 and decode_o.pc=0x80000000 at cycle 2, count_o=1.
- Fill (DEPTH=4):
  - Push 4 entries pc=0x100,0x104,0x108,0x10C with no ack -> count_o=4, fetch_ready_o=0.
  - Fifth push pc=0x110 is ignored.
  - Ack 4 times -> pcs out in order 0x100..0x10C, then valid=0.
- Streaming: push and ack every cycle for 12 entries, with the pointer wrapping 3 times -> count_o stays 1, output order exactly matches input order, and no entry is lost.
- Flush:
  - With 3 entries held, assert flush_i together with push pc=0x200 and ack -> next cycle count_o=0 and decode_o.valid=0.
  - A subsequent push of 0x300 appears alone.
- Exception passthrough: push an entry with ex.valid=1, cause=INSTR_PAGE_FAULT, tval=0xDEAD -> decode_o.ex equals the pushed value bit-exact.
- Reset mid-operation: rst_i=1 with count=2 and a simultaneous push -> count_o=0, fetch_ready_o=1 next cycle.
